// File: rtl/note_key_scanner_pkg.sv
// Shared note/octave codes for the key scanner and the tone stage it feeds.
// Note codes: 0 is silence, 1..7 map to C..B.
package note_key_scanner_pkg;

    typedef logic [2:0] note_t;
    typedef logic [2:0] octave_t;

    localparam note_t NOTE_NONE = 3'd0;
    localparam note_t NOTE_C    = 3'd1;
    localparam note_t NOTE_D    = 3'd2;
    localparam note_t NOTE_E    = 3'd3;
    localparam note_t NOTE_F    = 3'd4;
    localparam note_t NOTE_G    = 3'd5;
    localparam note_t NOTE_A    = 3'd6;
    localparam note_t NOTE_B    = 3'd7;

    localparam octave_t OCT_MIN = 3'd0;
    localparam octave_t OCT_MAX = 3'd7;

    // Lowest pressed key wins, so C takes priority over every higher key.
    function automatic note_t encode_note(input logic [6:0] keys);
        note_t result;
        result = NOTE_NONE;
        for (int unsigned i = 0; i < 7; i++) begin
            if (keys[i] && (result == NOTE_NONE)) begin
                result = note_t'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/note_key_scanner_button_debouncer.sv
// Two-flop synchroniser followed by a counter debouncer for one raw button.
// The debounced state flips only after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_100M,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Any sample matching the stable state falls through with cnt_d = 0.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_TERM) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/note_key_scanner.sv
// Key scanner top: debounces 7 note buttons and octave up/down, then registers
// the priority-encoded note code and a saturating octave register.
module note_key_scanner
    import note_key_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter logic [2:0]  OCT_DEFAULT     = 3'd4
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic [6:0] btn_note,
    input  logic       btn_oct_up,
    input  logic       btn_oct_dn,
    output logic [2:0] note,
    output logic [2:0] octave,
    output logic       note_on
);

    logic [6:0] note_stable;
    logic       up_stable;
    logic       dn_stable;

    for (genvar i = 0; i < 7; i++) begin : g_note_db
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_100M(clk_100M),
            .rst     (rst),
            .raw     (btn_note[i]),
            .stable  (note_stable[i])
        );
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_up (
        .clk_100M(clk_100M),
        .rst     (rst),
        .raw     (btn_oct_up),
        .stable  (up_stable)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_dn (
        .clk_100M(clk_100M),
        .rst     (rst),
        .raw     (btn_oct_dn),
        .stable  (dn_stable)
    );

    note_t   note_q, note_d;
    logic    note_on_q, note_on_d;
    octave_t octave_q, octave_d;
    logic    up_prev_q, up_prev_d;
    logic    dn_prev_q, dn_prev_d;
    logic    up_rise, dn_rise;

    always_comb begin
        note_d    = encode_note(note_stable);
        note_on_d = (note_d != NOTE_NONE);
        up_prev_d = up_stable;
        dn_prev_d = dn_stable;
        up_rise   = up_stable & ~up_prev_q;
        dn_rise   = dn_stable & ~dn_prev_q;
        octave_d  = octave_q;
        // Simultaneous up and down presses cancel out.
        if (up_rise && !dn_rise) begin
            if (octave_q != OCT_MAX) begin
                octave_d = octave_q + 3'd1;
            end
        end else if (dn_rise && !up_rise) begin
            if (octave_q != OCT_MIN) begin
                octave_d = octave_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            note_q    <= NOTE_NONE;
            note_on_q <= 1'b0;
            octave_q  <= OCT_DEFAULT;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            note_q    <= note_d;
            note_on_q <= note_on_d;
            octave_q  <= octave_d;
            up_prev_q <= up_prev_d;
            dn_prev_q <= dn_prev_d;
        end
    end

    assign note    = note_q;
    assign note_on = note_on_q;
    assign octave  = octave_q;

endmodule

// File: tb/tb_note_key_scanner.sv
// Directed bench for note_key_scanner with a 4-cycle debounce window.
// Raw input changes land just after an edge, so outputs follow 7 edges later.
module tb_note_key_scanner;

    logic       clk_100M;
    logic       rst;
    logic [6:0] btn_note;
    logic       btn_oct_up;
    logic       btn_oct_dn;
    logic [2:0] note;
    logic [2:0] octave;
    logic       note_on;

    int checks;
    int errors;
    int exp_oct;

    note_key_scanner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .OCT_DEFAULT    (3'd4)
    ) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .btn_note  (btn_note),
        .btn_oct_up(btn_oct_up),
        .btn_oct_dn(btn_oct_dn),
        .note      (note),
        .octave    (octave),
        .note_on   (note_on)
    );

    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int n_exp, input int on_exp, input int oct_exp);
        chk({tag, ".note"}, note, 3'(n_exp));
        chk({tag, ".note_on"}, {2'b00, note_on}, 3'(on_exp));
        chk({tag, ".octave"}, octave, 3'(oct_exp));
    endtask

    // Press and release octave buttons; octave should settle 7 edges after press.
    task automatic oct_press(input string tag, input logic up, input logic dn, input int exp);
        btn_oct_up = up;
        btn_oct_dn = dn;
        tick(7);
        chk(tag, octave, 3'(exp));
        btn_oct_up = 1'b0;
        btn_oct_dn = 1'b0;
        tick(7);
        chk({tag, ".rel"}, octave, 3'(exp));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        btn_note   = '0;
        btn_oct_up = 1'b0;
        btn_oct_dn = 1'b0;
        tick(2);
        chk_all("reset", 0, 0, 4);
        rst = 1'b0;
        tick(3);
        chk_all("idle", 0, 0, 4);

        // Single key E: visible exactly 7 edges after the raw change.
        btn_note = 7'b0000100;
        tick(6);
        chk_all("e_early", 0, 0, 4);
        tick(1);
        chk_all("e_on", 3, 1, 4);
        btn_note = '0;
        tick(7);
        chk_all("e_off", 0, 0, 4);

        // Bounce on C: 1-0-1 with 2-cycle gaps must not be accepted early.
        btn_note[0] = 1'b1;
        tick(2);
        chk("bounce_hi", note, 3'd0);
        btn_note[0] = 1'b0;
        tick(2);
        chk("bounce_lo", note, 3'd0);
        btn_note[0] = 1'b1;
        tick(6);
        chk("bounce_early", note, 3'd0);
        tick(1);
        chk_all("bounce_on", 1, 1, 4);
        btn_note = '0;
        tick(7);
        chk_all("bounce_off", 0, 0, 4);

        // Two keys: lowest wins, then the higher one after release.
        btn_note = 7'b1000010;
        tick(7);
        chk_all("multi", 2, 1, 4);
        btn_note = 7'b1000000;
        tick(6);
        chk("multi_hold", note, 3'd2);
        tick(1);
        chk_all("b_only", 7, 1, 4);
        btn_note = '0;
        tick(7);
        chk_all("all_off", 0, 0, 4);

        // Octave up five times from 4, saturating at 7.
        exp_oct = 4;
        for (int i = 0; i < 5; i++) begin
            exp_oct = (exp_oct < 7) ? exp_oct + 1 : 7;
            oct_press($sformatf("oct_up%0d", i), 1'b1, 1'b0, exp_oct);
        end
        oct_press("oct_dn_from7", 1'b0, 1'b1, 6);

        // Held buttons give exactly one step.
        btn_oct_dn = 1'b1;
        tick(7);
        chk("hold_dn_step", octave, 3'd5);
        tick(20);
        chk("hold_dn_20", octave, 3'd5);
        btn_oct_dn = 1'b0;
        tick(7);
        chk("hold_dn_rel", octave, 3'd5);
        btn_oct_up = 1'b1;
        tick(6);
        chk("hold_up_early", octave, 3'd5);
        tick(1);
        chk("hold_up_step", octave, 3'd6);
        tick(20);
        chk("hold_up_20", octave, 3'd6);
        btn_oct_up = 1'b0;
        tick(7);
        chk("hold_up_rel", octave, 3'd6);

        // Walk down to 0 and past it.
        exp_oct = 6;
        for (int i = 0; i < 8; i++) begin
            exp_oct = (exp_oct > 0) ? exp_oct - 1 : 0;
            oct_press($sformatf("oct_dn%0d", i), 1'b0, 1'b1, exp_oct);
        end
        oct_press("both_at0", 1'b1, 1'b1, 0);
        oct_press("up_to1", 1'b1, 1'b0, 1);
        oct_press("both_at1", 1'b1, 1'b1, 1);

        // Reset while buttons are held: immediate clear, then re-debounce.
        btn_note   = 7'b0000001;
        btn_oct_dn = 1'b1;
        tick(7);
        chk_all("pre_rst", 1, 1, 0);
        btn_oct_dn = 1'b0;
        btn_oct_up = 1'b1;
        tick(3);
        #3 rst = 1'b1;
        #1;
        chk_all("rst_async", 0, 0, 4);
        tick(1);
        rst = 1'b0;
        tick(6);
        chk_all("post_rst_early", 0, 0, 4);
        tick(1);
        chk_all("post_rst", 1, 1, 5);
        tick(10);
        chk("post_rst_hold", octave, 3'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
